key_debounce_reset: RTL
=======================

Name: key_debounce_reset

Overview:
Input-conditioning stage directly upstream of the SoCKit Qsys bridge. It synchronises and debounces the four raw active-low push-buttons, produces clean level and edge-pulse outputs, and generates the bridge's system reset. That reset is held for a programmable stretch after power-on reset and again after each press/release of the designated reset key. Replaces the direct KEY[3] wiring to the bridge reset.

Parameters:
NUM_KEYS, 4, number of push-button inputs
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a key change (20 ms at 50 MHz); legal range >= 2
RESET_KEY, 3, index of the key that triggers a system reset; must be < NUM_KEYS
RESET_STRETCH, 65536, cycles sys_reset_n is held low after reset source releases; legal range >= 2

Ports:
clk_clk  input  1  system clock, 50 MHz board oscillator
reset_reset_n  input  1  asynchronous active-low reset
key_n  input  NUM_KEYS  raw push-buttons, active-low, asynchronous to clk_clk
key_level  output  NUM_KEYS  debounced key state, 1 = pressed
key_press  output  NUM_KEYS  one-cycle pulse on accepted press
key_release  output  NUM_KEYS  one-cycle pulse on accepted release
sys_reset_n  output  1  active-low reset to bridge, registered

Behaviour:
- Reset is asynchronous and active-low on reset_reset_n. All state clears immediately on assertion, independent of clock.
- Reset values: synchroniser flops 1 (unpressed); key_level 0; key_press 0; key_release 0; debounce counters 0; FSM in STRETCH; stretch counter 0; sys_reset_n 0.
- Synchroniser, per key: two-flop chain on key_n, then inverted to give sync (1 = pressed).
- Debounce, per key: counter width $clog2(DEBOUNCE_CYCLES).
  - If sync == key_level: counter clears to 0.
  - If sync != key_level and counter < DEBOUNCE_CYCLES-1: counter increments.
  - If sync != key_level and counter == DEBOUNCE_CYCLES-1: key_level toggles on the next edge and counter clears.
  - Any single cycle of sync == key_level during counting restarts the count. Glitches shorter than DEBOUNCE_CYCLES are never accepted.
- Latency: a clean raw change appears on key_level exactly 2+DEBOUNCE_CYCLES rising edges after first being sampled.
- Pulses:
  - key_press[i] is 1 for exactly the cycle in which key_level[i] first reads 1.
  - key_release[i] is 1 for exactly the cycle in which key_level[i] first reads 0.
  - press and release are never both 1 for the same key.
  - Keys are fully independent; simultaneous changes on several keys produce simultaneous pulses.
- Reset sequencer FSM, states STRETCH, RUN, HELD:
  - STRETCH: stretch counter (width $clog2(RESET_STRETCH)) increments each cycle. At RESET_STRETCH-1 the FSM goes to RUN and the counter clears.
  - RUN: if key_level[RESET_KEY] == 1, go to HELD; otherwise stay.
  - HELD: stay while key_level[RESET_KEY] == 1. On 0, go to STRETCH with counter 0.
- sys_reset_n is registered: 1 only in cycles where the FSM is in RUN.
  - Assertion on a key press is synchronous: sys_reset_n falls in the same cycle the FSM first reads HELD, one cycle after key_press[RESET_KEY].
  - Deassertion is always synchronous to clk_clk.
  - Total low time after release of the reset key = RESET_STRETCH cycles.
- Asynchronous reset mid-operation (any state, counters mid-count) returns to STRETCH with sys_reset_n 0, restarting the full stretch.
- A key held through reset is re-debounced from key_level 0. If RESET_KEY is held through reset, the FSM enters HELD once the key is re-accepted.
- The RESET_KEY still produces normal key_level and pulse outputs.

Test Plan:
(Simulation parameters: DEBOUNCE_CYCLES=8, RESET_STRETCH=16.)
1. Release reset_reset_n at edge 0, all keys idle -> sys_reset_n 0 through edge 15, reads 1 from edge 16; key_level stays 0000, no pulses.
2. After RUN, drive key_n[0] low and hold -> key_level[0] rises at edge 10 after the change, with a 1-cycle key_press[0]. Release -> key_release[0] 10 edges later; sys_reset_n stays 1.
3. key_n[1] low for 5 cycles, high for 2, low for 5 (bounce) -> no key_level change or pulse. Then hold low -> accepted 10 edges after the final low transition.
4. In RUN, press key 3 for 40 cycles, then release -> sys_reset_n falls one cycle after key_press[3] and stays 0 while held. After key_release[3] it remains 0 for exactly 16 cycles, then returns to 1.
5. Press keys 0 and 2 on the same edge -> key_press = 0101 in a single cycle; level and pulses match per key.
6. Assert reset_reset_n mid-debounce and mid-stretch -> outputs clear immediately without a clock edge. After release, the full 16-cycle stretch repeats and a still-held key 0 is re-accepted 10 edges later.

Source files
------------

// File: rtl/key_debounce_reset.sv
// Push-button conditioning for the bridge: per-key 2-flop sync + debounce with
// press/release pulses, plus a stretched system reset driven by one key.

module key_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic rel
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;
  logic          sync;

  // sync_q[1] is the metastability-safe copy; invert so 1 = pressed
  assign sync = ~sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_n};
      press  <= 1'b0;
      rel    <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt   <= '0;
        level <= ~level;
        press <= ~level;
        rel   <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module key_debounce_reset #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RESET_KEY       = 3,
  parameter int RESET_STRETCH   = 65536
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                sys_reset_n
);
  localparam int SW = $clog2(RESET_STRETCH);
  localparam logic [SW-1:0] S_MAX = SW'(RESET_STRETCH - 1);

  typedef enum logic [1:0] {ST_STRETCH, ST_RUN, ST_HELD} state_t;

  state_t        state;
  logic [SW-1:0] s_cnt;
  logic          rk_level;

  key_debounce_lane #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_lane [NUM_KEYS-1:0] (
    .clk  (clk_clk),
    .rst_n(reset_reset_n),
    .key_n(key_n),
    .level(key_level),
    .press(key_press),
    .rel  (key_release)
  );

  assign rk_level = key_level[RESET_KEY];

  // sys_reset_n is registered alongside the state so it is high exactly in RUN
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state       <= ST_STRETCH;
      s_cnt       <= '0;
      sys_reset_n <= 1'b0;
    end else begin
      case (state)
        ST_STRETCH: begin
          if (s_cnt == S_MAX) begin
            state       <= ST_RUN;
            s_cnt       <= '0;
            sys_reset_n <= 1'b1;
          end else begin
            s_cnt       <= s_cnt + 1'b1;
            sys_reset_n <= 1'b0;
          end
        end
        ST_RUN: begin
          if (rk_level) begin
            state       <= ST_HELD;
            sys_reset_n <= 1'b0;
          end else begin
            sys_reset_n <= 1'b1;
          end
        end
        ST_HELD: begin
          sys_reset_n <= 1'b0;
          if (!rk_level) begin
            state <= ST_STRETCH;
            s_cnt <= '0;
          end
        end
        default: begin
          state       <= ST_STRETCH;
          s_cnt       <= '0;
          sys_reset_n <= 1'b0;
        end
      endcase
    end
  end
endmodule
